// File: rtl/dma_2d_burst_splitter.sv
// dma_2d_burst_splitter
//   Splits one 2D DMA descriptor into num_reps 1D burst requests, stepping
//   the source and destination addresses by their strides after every burst,
//   then counts backend completions and pulses done_o once the job is over.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_*_i, req_valid_i   2D descriptor; accepted when req_ready_o is high
//   req_ready_o            high only while idle
//   burst_*_o              registered 1D burst request (valid/ready)
//   burst_ready_i          backend takes the presented burst
//   trans_complete_i       one pulse per finished 1D burst
//   done_o                 one-cycle pulse at job end
//   busy_o                 high whenever a job is in flight (incl. done cycle)
module dma_2d_burst_splitter #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned RepWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IdWidth-1:0]   req_id_i,
   input  logic [AddrWidth-1:0] req_src_i,
   input  logic [AddrWidth-1:0] req_dst_i,
   input  logic [AddrWidth-1:0] req_num_bytes_i,
   input  logic [AddrWidth-1:0] req_src_stride_i,
   input  logic [AddrWidth-1:0] req_dst_stride_i,
   input  logic [RepWidth-1:0]  req_num_reps_i,
   input  logic                 req_decouple_rw_i,
   input  logic                 req_deburst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   output logic [IdWidth-1:0]   burst_id_o,
   output logic [AddrWidth-1:0] burst_src_o,
   output logic [AddrWidth-1:0] burst_dst_o,
   output logic [AddrWidth-1:0] burst_num_bytes_o,
   output logic                 burst_decouple_rw_o,
   output logic                 burst_deburst_o,
   output logic                 burst_valid_o,
   input  logic                 burst_ready_i,
   input  logic                 trans_complete_i,
   output logic                 done_o,
   output logic                 busy_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e               state;
   logic [AddrWidth-1:0] src_stride;
   logic [AddrWidth-1:0] dst_stride;
   logic [RepWidth-1:0]  num_reps;
   logic [RepWidth-1:0]  issued;
   logic [RepWidth-1:0]  completed;
   logic [RepWidth-1:0]  issued_next;
   logic [RepWidth-1:0]  completed_next;
   logic                 empty_job;

   assign req_ready_o = (state == IDLE);

   // Completed count including a pulse arriving this cycle, so WAIT can
   // leave in the same cycle the last completion shows up.
   always_comb begin
      issued_next    = issued + RepWidth'(1);
      completed_next = completed + RepWidth'(trans_complete_i);
      empty_job      = (req_num_reps_i == '0) || (req_num_bytes_i == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state               <= IDLE;
         src_stride          <= '0;
         dst_stride          <= '0;
         num_reps            <= '0;
         issued              <= '0;
         completed           <= '0;
         burst_id_o          <= '0;
         burst_src_o         <= '0;
         burst_dst_o         <= '0;
         burst_num_bytes_o   <= '0;
         burst_decouple_rw_o <= 1'b0;
         burst_deburst_o     <= 1'b0;
         burst_valid_o       <= 1'b0;
         done_o              <= 1'b0;
         busy_o              <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  busy_o <= 1'b1;
                  if (empty_job) begin
                     // Nothing to move: report completion straight away.
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state               <= ISSUE;
                     src_stride          <= req_src_stride_i;
                     dst_stride          <= req_dst_stride_i;
                     num_reps            <= req_num_reps_i;
                     issued              <= '0;
                     completed           <= '0;
                     burst_id_o          <= req_id_i;
                     burst_src_o         <= req_src_i;
                     burst_dst_o         <= req_dst_i;
                     burst_num_bytes_o   <= req_num_bytes_i;
                     burst_decouple_rw_o <= req_decouple_rw_i;
                     burst_deburst_o     <= req_deburst_i;
                     burst_valid_o       <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               completed <= completed_next;
               if (burst_valid_o && burst_ready_i) begin
                  // The output registers double as the current address
                  // counters; they only move on a handshake.
                  issued      <= issued_next;
                  burst_src_o <= burst_src_o + src_stride;
                  burst_dst_o <= burst_dst_o + dst_stride;
                  if (issued_next == num_reps) begin
                     burst_valid_o <= 1'b0;
                     state         <= WAIT;
                  end
               end
            end
            WAIT: begin
               completed <= completed_next;
               if (completed_next == num_reps) begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
